// File: rtl/axi4_lite_defs.sv
// ---------------------------------------------------------------------------
// axi4_lite_defs
// Shared AXI4-Lite definitions used by the write port (and the read port).
//   resp_t             : 2-bit BRESP/RRESP encoding
//   RESP_OKAY          : normal access completed
//   RESP_SLVERR        : access to an address with no register behind it
//   word_index_width() : width of the word index left after dropping the
//                        byte-offset bits of a byte address
// ---------------------------------------------------------------------------
package axi4_lite_defs;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    function automatic int word_index_width(input int addr_width, input int data_width);
        return addr_width - $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// ---------------------------------------------------------------------------
// axi4_lite_hold_reg
// One-entry holding register for a single AXI4-Lite request channel.
// Accepts one beat when empty, holds it until the consumer clears it.
//   axi_clk  in   clock, rising edge
//   resetn   in   synchronous, active-low reset
//   i_valid  in   upstream valid
//   o_ready  out  upstream ready (high while empty)
//   i_data   in   upstream payload
//   i_clear  in   consumer has taken the entry; empties it at the next edge
//   o_full   out  entry holds a beat
//   o_data   out  held payload
// ---------------------------------------------------------------------------
module axi4_lite_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             axi_clk,
    input  logic             resetn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // A load can only happen while empty and a clear only while full, so the
    // two never compete for the same edge.
    always_ff @(posedge axi_clk) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            r_full <= 1'b0;
            // NOTE: the payload is reset as well because it drives the sink
            // outputs directly, which must read zero out of reset.
            r_data <= '0;
        end else if (i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_lite_write_port.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_port
// AXI4-Lite write slave that turns AW+W pairs into single-cycle writes on a
// simple register-file sink port and returns OKAY/SLVERR on B.
//   axi_clk, resetn                              clock, sync active-low reset
//   write_addr, write_addr_valid/ready           AW channel (byte address)
//   write_data, write_strb, write_data_valid/ready  W channel
//   write_resp, write_resp_valid/ready           B channel
//   data_out, strb_out, addr_out (word index), data_valid   sink write port
// ---------------------------------------------------------------------------
module axi4_lite_write_port
    import axi4_lite_defs::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 4
) (
    input  logic                                axi_clk,
    input  logic                                resetn,
    input  logic [ADDRESS_WIDTH-1:0]            write_addr,
    input  logic                                write_addr_valid,
    output logic                                write_addr_ready,
    input  logic [DATA_WIDTH-1:0]               write_data,
    input  logic [DATA_WIDTH/8-1:0]             write_strb,
    input  logic                                write_data_valid,
    output logic                                write_data_ready,
    output logic [1:0]                          write_resp,
    output logic                                write_resp_valid,
    input  logic                                write_resp_ready,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic [DATA_WIDTH/8-1:0]             strb_out,
    output logic [word_index_width(ADDRESS_WIDTH, DATA_WIDTH)-1:0] addr_out,
    output logic                                data_valid
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = word_index_width(ADDRESS_WIDTH, DATA_WIDTH);
    localparam int W_W    = DATA_WIDTH + STRB_W;

    logic             w_aw_full;
    logic [IDX_W-1:0] w_aw_index;
    logic             w_w_full;
    logic [W_W-1:0]   w_w_payload;
    logic             w_commit;
    logic             w_in_range;
    logic             w_unused_offset;

    logic             r_resp_valid;
    resp_t            r_resp;

    // Byte-offset bits carry no information for whole-word registers.
    assign w_unused_offset = ^write_addr[OFF_W-1:0];

    axi4_lite_hold_reg #(
        .WIDTH (IDX_W)
    ) u_aw_hold (
        .axi_clk (axi_clk),
        .resetn  (resetn),
        .i_valid (write_addr_valid),
        .o_ready (write_addr_ready),
        .i_data  (write_addr[ADDRESS_WIDTH-1:OFF_W]),
        .i_clear (w_commit),
        .o_full  (w_aw_full),
        .o_data  (w_aw_index)
    );

    axi4_lite_hold_reg #(
        .WIDTH (W_W)
    ) u_w_hold (
        .axi_clk (axi_clk),
        .resetn  (resetn),
        .i_valid (write_data_valid),
        .o_ready (write_data_ready),
        .i_data  ({write_strb, write_data}),
        .i_clear (w_commit),
        .o_full  (w_w_full),
        .o_data  (w_w_payload)
    );

    // A pair may commit whenever the B slot is free or is being freed this
    // cycle, which lets back-to-back responses run without a bubble.
    assign w_commit   = w_aw_full && w_w_full && (!r_resp_valid || write_resp_ready);

    // Extra bit keeps the compare exact when NUM_REGS == 2**IDX_W.
    assign w_in_range = ({1'b0, w_aw_index} < (IDX_W + 1)'(NUM_REGS));

    assign data_valid = w_commit && w_in_range;
    assign data_out   = w_w_payload[DATA_WIDTH-1:0];
    assign strb_out   = w_w_payload[W_W-1:DATA_WIDTH];
    assign addr_out   = w_aw_index;

    always_ff @(posedge axi_clk) begin
        if (!resetn) begin
            r_resp_valid <= 1'b0;
            r_resp       <= RESP_OKAY;
        end else if (w_commit) begin
            r_resp_valid <= 1'b1;
            r_resp       <= w_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (write_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign write_resp_valid = r_resp_valid;
    assign write_resp       = r_resp;

endmodule
